// File: rtl/spi_target_pkg.sv
// spi_target_pkg
//
// Shared definitions for the SPI register target: bus widths, register file
// depth, the frame FSM state encoding and a small bit-counter helper.
package spi_target_pkg;

    localparam int ADDR_W    = 7;
    localparam int DATA_W    = 8;
    localparam int REG_DEPTH = 128;
    localparam int BIT_CNT_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CMD  = 2'd1,
        ST_DATA = 2'd2,
        ST_HOLD = 2'd3
    } state_t;

    // A chip-select release is clean only when no byte is partially shifted.
    function automatic logic on_byte_boundary(input logic [BIT_CNT_W-1:0] cnt);
        return (cnt == 4'd0) || (cnt == 4'd8);
    endfunction

endpackage

// File: rtl/spi_target_sync.sv
// spi_target_sync
//
// N-stage synchronizer for one asynchronous pin followed by a single-flop
// edge detector.
//
// Parameters:
//   SYNC_STAGES - number of synchronizer flops (>= 2)
//   RESET_VAL   - value loaded into every flop on reset
// Ports:
//   clk      in  fabric clock
//   reset_n  in  synchronous reset, active low
//   pin      in  asynchronous input
//   level    out synchronized level
//   rise     out 1-cycle strobe on a synchronized 0->1 transition
//   fall     out 1-cycle strobe on a synchronized 1->0 transition
module spi_target_sync #(
    parameter int   SYNC_STAGES = 2,
    parameter logic RESET_VAL   = 1'b0
) (
    input  logic clk,
    input  logic reset_n,
    input  logic pin,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] stages;
    logic                   prev;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            stages <= {SYNC_STAGES{RESET_VAL}};
            prev   <= RESET_VAL;
        end else begin
            stages <= {stages[SYNC_STAGES-2:0], pin};
            prev   <= stages[SYNC_STAGES-1];
        end
    end

    assign level = stages[SYNC_STAGES-1];
    assign rise  = level & ~prev;
    assign fall  = ~level & prev;

endmodule

// File: rtl/spi_target_regs.sv
// spi_target_regs
//
// SPI target (mode 3, MSB first) answering the register protocol: one command
// byte {rw, addr[6:0]} (rw = 1 reads) followed by data bytes. Backs a 128 x 8
// register file shared with a local fabric port; SPI writes win collisions.
//
// Build option: define SPI_TARGET_AUTOINC_EN to auto-increment the address
// after every data byte (burst access). Without it the frame holds after the
// first data byte.
//
// Parameters:
//   SYNC_STAGES   - synchronizer depth on sclk, cs_n and mosi (>= 2)
// Ports:
//   clk           in  fabric clock
//   reset_n       in  synchronous reset, active low
//   sclk          in  SPI clock (async, idles high)
//   cs_n          in  chip select, active low (async)
//   mosi          in  controller-to-target data
//   miso          out target-to-controller data (1 when not driving)
//   miso_oe       out high while miso carries read data
//   loc_we        in  local write enable
//   loc_addr      in  local write address
//   loc_wdata     in  local write data
//   loc_raddr     in  local read address
//   loc_rdata     out local read data, 1-cycle latency
//   spi_wr_valid  out pulse per committed SPI write
//   spi_wr_addr   out address of the committed SPI write
//   spi_wr_data   out data of the committed SPI write
//   busy          out FSM not idle
//   frame_err     out pulse when cs_n rises mid-byte
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | waiting for chip select to fall
// CMD     | shifting in the command byte
// DATA    | read: shifting register bytes out; write: shifting bytes in
// HOLD    | single-byte access finished, sclk ignored until cs_n rises
module spi_target_regs
    import spi_target_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              sclk,
    input  logic              cs_n,
    input  logic              mosi,
    output logic              miso,
    output logic              miso_oe,
    input  logic              loc_we,
    input  logic [ADDR_W-1:0] loc_addr,
    input  logic [DATA_W-1:0] loc_wdata,
    input  logic [ADDR_W-1:0] loc_raddr,
    output logic [DATA_W-1:0] loc_rdata,
    output logic              spi_wr_valid,
    output logic [ADDR_W-1:0] spi_wr_addr,
    output logic [DATA_W-1:0] spi_wr_data,
    output logic              busy,
    output logic              frame_err
);

    logic sclk_rise, sclk_fall, sclk_level_unused;
    logic cs_rise, cs_fall, cs_level_unused;
    logic mosi_s, mosi_rise_unused, mosi_fall_unused;

    spi_target_sync #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_sclk (
        .clk     (clk),
        .reset_n (reset_n),
        .pin     (sclk),
        .level   (sclk_level_unused),
        .rise    (sclk_rise),
        .fall    (sclk_fall)
    );

    // Reset treats chip select as already asserted so a frame in progress at
    // reset release cannot produce a cs_fall; the target waits for cs_n high.
    spi_target_sync #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_cs (
        .clk     (clk),
        .reset_n (reset_n),
        .pin     (cs_n),
        .level   (cs_level_unused),
        .rise    (cs_rise),
        .fall    (cs_fall)
    );

    spi_target_sync #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_mosi (
        .clk     (clk),
        .reset_n (reset_n),
        .pin     (mosi),
        .level   (mosi_s),
        .rise    (mosi_rise_unused),
        .fall    (mosi_fall_unused)
    );

    state_t                 state_q, state_d;
    logic [BIT_CNT_W-1:0]   bit_cnt;
    logic [DATA_W-1:0]      rx_sr;
    logic [DATA_W-1:0]      tx_sr;
    logic                   rw;
    logic [ADDR_W-1:0]      addr;
    logic                   first_fall;
    logic                   load_pending;
    logic [DATA_W-1:0]      mem [REG_DEPTH];

    logic                   frame_start;
    logic                   shift_en;
    logic                   byte_done;
    logic                   err_d;
    logic                   spi_commit;
    logic [DATA_W-1:0]      rx_byte;
    logic                   tx_active;

    assign rx_byte    = {rx_sr[DATA_W-2:0], mosi_s};
    assign spi_commit = byte_done && (state_q == ST_DATA) && !rw;
    assign tx_active  = (state_q == ST_DATA) && rw;

    always_comb begin
        state_d     = state_q;
        frame_start = 1'b0;
        shift_en    = 1'b0;
        byte_done   = 1'b0;
        err_d       = 1'b0;
        if (cs_rise) begin
            state_d = ST_IDLE;
            err_d   = !on_byte_boundary(bit_cnt);
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (cs_fall) begin
                        state_d     = ST_CMD;
                        frame_start = 1'b1;
                    end
                end
                ST_CMD: begin
                    if (sclk_rise) begin
                        shift_en = 1'b1;
                        if (bit_cnt == 4'd7) begin
                            byte_done = 1'b1;
                            state_d   = ST_DATA;
                        end
                    end
                end
                ST_DATA: begin
                    if (sclk_rise) begin
                        shift_en = 1'b1;
                        if (bit_cnt == 4'd7) begin
                            byte_done = 1'b1;
`ifdef SPI_TARGET_AUTOINC_EN
                            state_d   = ST_DATA;
`else
                            state_d   = ST_HOLD;
`endif
                        end
                    end
                end
                ST_HOLD: begin
                    state_d = ST_HOLD;
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q      <= ST_IDLE;
            bit_cnt      <= '0;
            rx_sr        <= '0;
            tx_sr        <= '0;
            rw           <= 1'b0;
            addr         <= '0;
            first_fall   <= 1'b0;
            load_pending <= 1'b0;
            miso         <= 1'b1;
            spi_wr_valid <= 1'b0;
            spi_wr_addr  <= '0;
            spi_wr_data  <= '0;
            frame_err    <= 1'b0;
        end else begin
            state_q      <= state_d;
            frame_err    <= err_d;
            spi_wr_valid <= 1'b0;
            load_pending <= 1'b0;

            if (frame_start || cs_rise) begin
                bit_cnt <= '0;
            end else if (shift_en) begin
                rx_sr   <= rx_byte;
                bit_cnt <= byte_done ? '0 : bit_cnt + 4'd1;
            end

            if (byte_done && (state_q == ST_CMD)) begin
                rw           <= rx_byte[DATA_W-1];
                addr         <= rx_byte[ADDR_W-1:0];
                load_pending <= rx_byte[DATA_W-1];
            end

            if (byte_done && (state_q == ST_DATA)) begin
                if (!rw) begin
                    spi_wr_valid <= 1'b1;
                    spi_wr_addr  <= addr;
                    spi_wr_data  <= rx_byte;
                end
`ifdef SPI_TARGET_AUTOINC_EN
                addr         <= addr + 7'd1;
                load_pending <= rw;
`endif
            end

            // The byte is captured here, so later local writes to the same
            // register do not disturb a byte already being shifted out.
            if (load_pending) begin
                tx_sr      <= mem[addr];
                first_fall <= 1'b1;
            end else if (tx_active && sclk_fall) begin
                if (first_fall) begin
                    miso       <= tx_sr[DATA_W-1];
                    first_fall <= 1'b0;
                end else begin
                    miso  <= tx_sr[DATA_W-2];
                    tx_sr <= {tx_sr[DATA_W-2:0], 1'b0};
                end
            end

            if (state_q != ST_DATA) begin
                miso <= 1'b1;
            end
        end
    end

    // Local write is issued first; the SPI commit assigned afterwards takes
    // precedence when both target the same address in one cycle.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            for (int i = 0; i < REG_DEPTH; i++) begin
                mem[i] <= '0;
            end
            loc_rdata <= '0;
        end else begin
            if (loc_we) begin
                mem[loc_addr] <= loc_wdata;
            end
            if (spi_commit) begin
                mem[addr] <= rx_byte;
            end
            loc_rdata <= mem[loc_raddr];
        end
    end

    assign miso_oe = tx_active;
    assign busy    = (state_q != ST_IDLE);

endmodule

// File: tb/tb_spi_target_regs.sv
module tb_spi_target_regs;

`ifdef SPI_TARGET_AUTOINC_EN
    localparam bit AUTOINC = 1'b1;
`else
    localparam bit AUTOINC = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       sclk = 1'b1;
    logic       cs_n = 1'b1;
    logic       mosi = 1'b0;
    logic       loc_we = 1'b0;
    logic [6:0] loc_addr = '0;
    logic [7:0] loc_wdata = '0;
    logic [6:0] loc_raddr = '0;
    logic       miso, miso_oe, spi_wr_valid, busy, frame_err;
    logic [7:0] loc_rdata, spi_wr_data;
    logic [6:0] spi_wr_addr;

    always #5 clk = ~clk;

    spi_target_regs #(.SYNC_STAGES(2)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .sclk         (sclk),
        .cs_n         (cs_n),
        .mosi         (mosi),
        .miso         (miso),
        .miso_oe      (miso_oe),
        .loc_we       (loc_we),
        .loc_addr     (loc_addr),
        .loc_wdata    (loc_wdata),
        .loc_raddr    (loc_raddr),
        .loc_rdata    (loc_rdata),
        .spi_wr_valid (spi_wr_valid),
        .spi_wr_addr  (spi_wr_addr),
        .spi_wr_data  (spi_wr_data),
        .busy         (busy),
        .frame_err    (frame_err)
    );

    // Reference register file and expectation queues
    logic [7:0]  model [128];
    logic [7:0]  q_rd[$];
    logic [14:0] q_wr[$];
    int          q_oe[$];
    bit          q_err[$];
    logic [7:0]  q_lrd[$];
    int          lrd_req = 0;
    int          rst_req = 0;
    bit          done_req = 1'b0;

    int n_checks = 0;
    int n_pass = 0;

    function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endfunction

    function automatic void unexpected(string name);
        n_checks++;
        $display("FAIL %s: got an event, expected none", name);
    endfunction

    // Monitor / scoreboard
    initial begin
        logic       sclk_prev = 1'b1;
        logic       cs_prev = 1'b1;
        int         oe_bits = 0;
        int         rd_cnt = 0;
        logic [7:0] rd_sr = '0;
        int         lrd_seen = 0;
        int         rst_seen = 0;
        forever begin
            @(posedge clk);
            #1;
            if (rst_req != rst_seen) begin
                rst_seen = rst_req;
                check("reset_outputs", 32'({miso, miso_oe, busy, spi_wr_valid, frame_err}), 32'h10);
                check("reset_wr_bus", 32'({spi_wr_addr, spi_wr_data, loc_rdata}), 32'h0);
            end
            if (sclk && !sclk_prev && (miso_oe === 1'b1)) begin
                oe_bits++;
                rd_sr = {rd_sr[6:0], miso};
                rd_cnt++;
                if (rd_cnt == 8) begin
                    rd_cnt = 0;
                    if (q_rd.size() == 0) unexpected("spi_rd_byte");
                    else check("spi_rd_byte", 32'(rd_sr), 32'(q_rd.pop_front()));
                end
            end
            if (cs_n && !cs_prev) begin
                rd_cnt = 0;
                if (q_oe.size() == 0) unexpected("cs_release");
                else check("miso_oe_bits", 32'(oe_bits), 32'(q_oe.pop_front()));
                oe_bits = 0;
            end
            if (spi_wr_valid === 1'b1) begin
                if (q_wr.size() == 0) unexpected("spi_wr_valid");
                else check("spi_wr_addr_data", 32'({spi_wr_addr, spi_wr_data}), 32'(q_wr.pop_front()));
            end
            if (frame_err === 1'b1) begin
                if (q_err.size() == 0) unexpected("frame_err");
                else check("frame_err", 32'(frame_err), 32'(q_err.pop_front()));
            end
            if (lrd_req != lrd_seen) begin
                lrd_seen = lrd_req;
                if (q_lrd.size() == 0) unexpected("loc_rdata");
                else check("loc_rdata", 32'(loc_rdata), 32'(q_lrd.pop_front()));
            end
            if (done_req) begin
                check("rd_left", 32'(q_rd.size()), 32'd0);
                check("wr_left", 32'(q_wr.size()), 32'd0);
                check("err_left", 32'(q_err.size()), 32'd0);
                check("oe_left", 32'(q_oe.size()), 32'd0);
                $display("%0d/%0d checks passed", n_pass, n_checks);
                $finish;
            end
            sclk_prev = sclk;
            cs_prev = cs_n;
        end
    end

    initial begin
        #600000;
        $display("FAIL timeout: simulation did not complete, %0d/%0d checks passed", n_pass, n_checks);
        $fatal(1, "timeout");
    end

    // Stimulus tasks (entered and left on a falling clk edge)
    task automatic send_bits(input logic [7:0] b, input int nbits,
                             input bit collide, input logic [6:0] ca, input logic [7:0] cd);
        for (int i = 0; i < nbits; i++) begin
            sclk = 1'b0;
            mosi = b[7-i];
            repeat (4) @(negedge clk);
            sclk = 1'b1;
            if (collide && (i == 7)) begin
                // Commit happens on the third clk edge after the pin rise.
                @(negedge clk);
                @(negedge clk);
                loc_we = 1'b1;
                loc_addr = ca;
                loc_wdata = cd;
                @(negedge clk);
                loc_we = 1'b0;
                @(negedge clk);
            end else begin
                repeat (4) @(negedge clk);
            end
        end
    endtask

    task automatic frame_begin();
        cs_n = 1'b0;
        repeat (5) @(negedge clk);
    endtask

    task automatic frame_end();
        cs_n = 1'b1;
        repeat (8) @(negedge clk);
    endtask

    task automatic loc_write(input logic [6:0] a, input logic [7:0] d);
        loc_we = 1'b1;
        loc_addr = a;
        loc_wdata = d;
        @(negedge clk);
        loc_we = 1'b0;
        model[a] = d;
    endtask

    task automatic loc_read(input logic [6:0] a);
        loc_raddr = a;
        q_lrd.push_back(model[a]);
        @(posedge clk);
        lrd_req++;
        @(negedge clk);
    endtask

    task automatic spi_write(input logic [6:0] a, input int n, input logic [7:0] b0,
                             input logic [7:0] b1, input logic [7:0] b2,
                             input bit collide, input logic [7:0] cd);
        logic [7:0] bytes [3];
        logic [6:0] wa;
        bytes[0] = b0;
        bytes[1] = b1;
        bytes[2] = b2;
        q_oe.push_back(0);
        for (int k = 0; k < n; k++) begin
            if (AUTOINC || k == 0) begin
                wa = a + 7'(k);
                q_wr.push_back({wa, bytes[k]});
                model[wa] = bytes[k];
            end
        end
        frame_begin();
        send_bits({1'b0, a}, 8, 1'b0, '0, '0);
        for (int k = 0; k < n; k++) send_bits(bytes[k], 8, collide && (k == 0), a, cd);
        frame_end();
    endtask

    task automatic spi_read(input logic [6:0] a, input int n);
        q_oe.push_back(AUTOINC ? 8 * n : 8);
        for (int k = 0; k < n; k++) begin
            if (AUTOINC || k == 0) q_rd.push_back(model[a + 7'(k)]);
        end
        frame_begin();
        send_bits({1'b1, a}, 8, 1'b0, '0, '0);
        for (int k = 0; k < n; k++) send_bits(8'($urandom), 8, 1'b0, '0, '0);
        frame_end();
    endtask

    initial begin
        for (int i = 0; i < 128; i++) model[i] = 8'h00;
        repeat (5) @(negedge clk);
        rst_req++;
        @(negedge clk);
        reset_n = 1'b1;
        repeat (3) @(negedge clk);
        loc_read(7'h5A);

        // Write 0x20 <- 0xA5 and read it back locally
        spi_write(7'h20, 1, 8'hA5, 8'h00, 8'h00, 1'b0, 8'h00);
        loc_read(7'h20);

        // Local write then SPI read
        loc_write(7'h0F, 8'h3C);
        spi_read(7'h0F, 1);

        // Burst read across the address wrap
        loc_write(7'h7F, 8'h11);
        loc_write(7'h00, 8'h22);
        loc_write(7'h01, 8'h33);
        spi_read(7'h7F, 3);

        // Chip select released after 4 data bits
        loc_write(7'h05, 8'h96);
        q_oe.push_back(0);
        q_err.push_back(1'b1);
        frame_begin();
        send_bits(8'h05, 8, 1'b0, '0, '0);
        send_bits(8'hE7, 4, 1'b0, '0, '0);
        frame_end();
        loc_read(7'h05);

        // Same-cycle SPI commit and local write
        spi_write(7'h10, 1, 8'h55, 8'h00, 8'h00, 1'b1, 8'hAA);
        loc_read(7'h10);

        // Reset mid-frame, released with cs_n still low
        q_oe.push_back(0);
        frame_begin();
        send_bits(8'h31, 4, 1'b0, '0, '0);
        reset_n = 1'b0;
        for (int i = 0; i < 128; i++) model[i] = 8'h00;
        repeat (4) @(negedge clk);
        rst_req++;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        repeat (3) @(negedge clk);
        send_bits(8'h31, 8, 1'b0, '0, '0);
        send_bits(8'h77, 8, 1'b0, '0, '0);
        frame_end();
        loc_read(7'h31);
        loc_read(7'h20);
        spi_write(7'h31, 1, 8'h77, 8'h00, 8'h00, 1'b0, 8'h00);
        loc_read(7'h31);

        // Randomized traffic
        for (int it = 0; it < 30; it++) begin
            logic [6:0] a;
            int op, n;
            op = int'($urandom_range(0, 3));
            a = 7'($urandom_range(0, 127));
            n = int'($urandom_range(1, 3));
            case (op)
                0: loc_write(a, 8'($urandom));
                1: spi_write(a, n, 8'($urandom), 8'($urandom), 8'($urandom), 1'b0, 8'h00);
                2: spi_read(a, n);
                default: loc_read(a);
            endcase
        end
        for (int i = 0; i < 6; i++) loc_read(7'($urandom_range(0, 127)));

        repeat (10) @(negedge clk);
        done_req = 1'b1;
    end

endmodule
